// File: rtl/vga_line_fetcher_if.sv
// Port bundle of the line fetcher: DDR read handshake, frame control and pixel FIFO pop side.
// master = the surrounding logic (timing generator, DDR controller, pixel pipe); slave = the fetcher.
interface vga_line_fetcher_if;
  logic        frameStart;
  logic        read;
  logic [23:0] readAddress;
  logic        readAcknowledge;
  logic [15:0] readData;
  logic [15:0] pixelData;
  logic        pixelValid;
  logic        pixelRead;
  logic        frameDone;
  logic        underflow;

  modport master (
    output frameStart, readAcknowledge, readData, pixelRead,
    input  read, readAddress, pixelData, pixelValid, frameDone, underflow
  );

  modport slave (
    input  frameStart, readAcknowledge, readData, pixelRead,
    output read, readAddress, pixelData, pixelValid, frameDone, underflow
  );
endinterface

// File: rtl/vga_line_fetcher.sv
// Framebuffer read prefetcher: walks one frame of word addresses through a level
// request/acknowledge DDR read port and buffers the words in a FWFT FIFO.
//
// state      | meaning
// ST_IDLE    | no request outstanding; issue when active, FIFO has room and ack is low
// ST_REQ     | read held high with a stable address until the controller acknowledges
// ST_RELEASE | read dropped; waiting for the controller to drop its acknowledge
module vga_line_fetcher #(
  parameter logic [23:0] FRAME_BASE      = 24'h000000,
  parameter int unsigned FRAME_WORDS     = 307200,
  parameter int unsigned FIFO_DEPTH_LOG2 = 4
) (
  input logic               clk133_p,
  input logic               rst,
  vga_line_fetcher_if.slave bus
);

  localparam int unsigned DEPTH = 1 << FIFO_DEPTH_LOG2;
  localparam logic [23:0] LAST_ADDR = FRAME_BASE + 24'(FRAME_WORDS - 1);
  localparam logic [FIFO_DEPTH_LOG2:0] FULL_COUNT = (FIFO_DEPTH_LOG2 + 1)'(DEPTH);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_REQ     = 2'd1,
    ST_RELEASE = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic                       read_q;
  logic [23:0]                addr_q;
  logic                       active_q;
  logic                       discard_q;
  logic                       done_q;
  logic                       underflow_q;
  logic [15:0]                mem [DEPTH];
  logic [FIFO_DEPTH_LOG2-1:0] wr_ptr;
  logic [FIFO_DEPTH_LOG2-1:0] rd_ptr;
  logic [FIFO_DEPTH_LOG2:0]   count;

  logic issue;
  logic accept;
  logic push;
  logic pop;
  logic stale_req;

  // State register.
  always_ff @(posedge clk133_p or negedge rst) begin
    if (!rst) state <= ST_IDLE;
    else      state <= state_nxt;
  end

  // Next-state decode of the request/acknowledge handshake.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:    if (issue)                 state_nxt = ST_REQ;
      ST_REQ:     if (bus.readAcknowledge)   state_nxt = ST_RELEASE;
      ST_RELEASE: if (!bus.readAcknowledge)  state_nxt = ST_IDLE;
      default:                               state_nxt = ST_IDLE;
    endcase
  end

  // Handshake and FIFO strobes; a frame restart suppresses both push and pop.
  always_comb begin
    issue     = active_q && (count < FULL_COUNT) && !bus.readAcknowledge;
    accept    = (state == ST_REQ) && bus.readAcknowledge;
    push      = accept && !discard_q && !bus.frameStart;
    pop       = bus.pixelRead && (count != '0) && !bus.frameStart;
    stale_req = bus.frameStart && (state == ST_REQ) && !bus.readAcknowledge;
  end

  // read is registered so it rises on the edge that enters REQ and falls on the accepting edge.
  always_ff @(posedge clk133_p or negedge rst) begin
    if (!rst) read_q <= 1'b0;
    else      read_q <= (state_nxt == ST_REQ);
  end

  // Address walk. An unacknowledged request keeps its address; the restart is applied
  // when that request completes, so the controller never sees the address move under read.
  always_ff @(posedge clk133_p or negedge rst) begin
    if (!rst) begin
      addr_q <= FRAME_BASE;
    end else if (bus.frameStart) begin
      if (!stale_req) addr_q <= FRAME_BASE;
    end else if (accept) begin
      addr_q <= discard_q ? FRAME_BASE : addr_q + 24'd1;
    end
  end

  // Frame progress: active/done flags and the discard marker for a restarted request.
  always_ff @(posedge clk133_p or negedge rst) begin
    if (!rst) begin
      active_q  <= 1'b0;
      done_q    <= 1'b0;
      discard_q <= 1'b0;
    end else begin
      if (bus.frameStart) begin
        active_q <= 1'b1;
        done_q   <= 1'b0;
      end else if (push && (addr_q == LAST_ADDR)) begin
        active_q <= 1'b0;
        done_q   <= 1'b1;
      end
      if (stale_req)   discard_q <= 1'b1;
      else if (accept) discard_q <= 1'b0;
    end
  end

  // FIFO pointers and occupancy; a restart flushes everything.
  always_ff @(posedge clk133_p or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (bus.frameStart) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // FIFO storage; contents need no reset since pixelValid gates them.
  always_ff @(posedge clk133_p) begin
    if (push) mem[wr_ptr] <= bus.readData;
  end

  // Sticky underflow on a pop attempt while empty.
  always_ff @(posedge clk133_p or negedge rst) begin
    if (!rst)                                  underflow_q <= 1'b0;
    else if (bus.frameStart)                   underflow_q <= 1'b0;
    else if (bus.pixelRead && (count == '0))   underflow_q <= 1'b1;
  end

  assign bus.read        = read_q;
  assign bus.readAddress = addr_q;
  assign bus.pixelData   = mem[rd_ptr];
  assign bus.pixelValid  = (count != '0);
  assign bus.frameDone   = done_q;
  assign bus.underflow   = underflow_q;

endmodule

// File: doc/vga_line_fetcher.md
# vga_line_fetcher

Read-side prefetcher sitting directly upstream of the DDR controller's read port and downstream of nothing but the VGA timing logic. Each frame it walks a linear framebuffer region, issues one 16-bit read per word through the controller's level request/acknowledge handshake, and buffers the returned words in a small first-word-fall-through FIFO. The VGA pixel pipeline pops from that FIFO. Flow control comes from FIFO occupancy, so the DDR controller is never asked for more than the FIFO can hold.

## Interface
Parameters:
- `FRAME_BASE`, 24'h000000: word address of the first framebuffer word.
- `FRAME_WORDS`, 307200: words per frame (640x480, one 16-bit pixel per word); must be 1 or more.
- `FIFO_DEPTH_LOG2`, 4: FIFO depth is 2^N words (16).

Ports:
- `clk133_p`  in  1  system clock; all state changes on the rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `frameStart`  in  1  one-cycle pulse; starts a new frame fetch.
- `read`  out  1  read request to the DDR controller.
- `readAddress`  out  24  word address presented with `read`.
- `readAcknowledge`  in  1  from the controller; high means `readData` is valid; drops only after `read` drops.
- `readData`  in  16  returned word.
- `pixelData`  out  16  FIFO head, combinational.
- `pixelValid`  out  1  FIFO not empty.
- `pixelRead`  in  1  pop the head this cycle.
- `frameDone`  out  1  all `FRAME_WORDS` words fetched for the current frame.
- `underflow`  out  1  sticky: `pixelRead` while empty; cleared by `frameStart`.

## Operation
- Fetch FSM states:
  - IDLE: if `active`, `count < 2^N` and `readAcknowledge == 0`, then `read <= 1` and go to REQ.
  - REQ: hold `read` and `readAddress`. When `readAcknowledge == 1`:
    - push `readData` into the FIFO, unless `discard` is set;
    - clear `discard`;
    - `read <= 0`;
    - advance the address;
    - go to RELEASE.
  - RELEASE: wait for `readAcknowledge == 0`, then go to IDLE.
- Address handling:
  - Address increments by 1 per accepted word.
  - When the word at `FRAME_BASE + FRAME_WORDS - 1` is accepted, `active` clears and `frameDone` sets.
  - 24-bit arithmetic. The region must not cross 2^24; no internal wrap is required.
- `frameStart` (any state):
  - Flush the FIFO: count 0, pointers 0.
  - Reload `readAddress` with `FRAME_BASE`.
  - Set `active`; clear `frameDone` and `underflow`.
  - If the FSM is in REQ, set `discard` and keep `read` high until acknowledged. The in-flight handshake always completes and is never aborted.
  - After that handshake, fetching restarts at `FRAME_BASE`: the address reload takes priority over the REQ-exit increment.
- `frameStart` in RELEASE: the handshake finishes normally and the next request is `FRAME_BASE`.
- FIFO:
  - First-word-fall-through, 2^N x 16.
  - Occupancy counter `count` is N+1 bits wide and ranges 0..2^N.
  - Push and pop in the same cycle leaves `count` unchanged.
  - Pop while empty is ignored and sets `underflow`.
  - Overflow cannot occur: a request is only issued when `count < 2^N`, and pops only free space.
- Simultaneous `frameStart` and push or pop: the flush wins, and the pushed word is dropped.

## Timing
- Reset values:
  - FSM in IDLE;
  - `read` 0;
  - `readAddress` `FRAME_BASE`;
  - `active` 0;
  - `discard` 0;
  - FIFO empty, so `pixelValid` 0 and `pixelData` is don't-care;
  - `frameDone` 0;
  - `underflow` 0.
- After reset, nothing is fetched until the first `frameStart`.
- `read` rises on the edge after an IDLE cycle that meets the issue conditions.
- A word accepted in REQ is visible at `pixelData` with `pixelValid` 1 on the following cycle.
- Each handshake takes at least 1 REQ + 1 RELEASE + 1 IDLE cycle, plus the controller's latency.
- `readAddress` is stable from the rise of `read` until the cycle after `readAcknowledge` is seen high.
- `frameDone` rises on the edge that accepts the final word.

## Test plan
- Reset, then `frameStart` with an ideal controller model (ack 4 cycles after `read`, data = low 16 bits of address), `pixelRead` held low. Required: exactly 16 requests at addresses 0..15; `read` stays 0 afterwards; `pixelValid` 1; `pixelData` = 0x0000.
- Continuous `pixelRead` with `FRAME_WORDS` = 40. Required: popped sequence is 0..39 in order; `frameDone` rises after word 39; `underflow` stays 0 while data leads; no 41st request.
- `frameStart` while in REQ for address 7, with FIFO holding 0..6. Required: FIFO empties on the next cycle; word 7 is discarded; the next request is address 0; first popped value is 0x0000.
- Controller delays dropping `readAcknowledge` by 3 cycles after `read` falls. Required: FSM stays in RELEASE; no new `read` until ack is 0; no duplicate push.
- `pixelRead` asserted with the FIFO empty. Required: `underflow` becomes 1 and stays 1; `count` stays 0; the next `frameStart` clears `underflow`.
- Assert `rst` low mid-REQ. Required: `read` becomes 0 immediately; FIFO empty; `readAddress` = `FRAME_BASE`; no fetch until the next `frameStart`.
